// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between three requesters
//   0 = host (kvaz), 1 = floppy workhorse window, 2 = auxiliary (OSD/loader).
// Optional build macro SDRAM_ARB_HOSTPRIO_EN: requester 0 wins every IDLE
// decision when pending; requesters 1 and 2 alternate between themselves.
// Without the macro the arbiter is a plain 3-way round-robin.
//
// Handshake semantics (requester side): a one-cycle req_rd/req_wr strobe is
// captured on the next edge when the slot is free; req_busy[i] is high from
// that capture edge until the completion edge. Strobes seen while busy are
// dropped. Controller side: mem_rd/mem_wr is a one-cycle command pulse with
// mem_addr/mem_wdata held stable until mem_ack, a one-cycle completion that
// qualifies mem_rdata. Only one controller access is outstanding at a time.
`timescale 1ns/1ps
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req_rd,
  input  logic [2:0]              req_wr,
  input  logic [3*ADDR_WIDTH-1:0] req_addr,
  input  logic [3*DATA_WIDTH-1:0] req_wdata,
  output logic [2:0]              req_busy,
  output logic [3*DATA_WIDTH-1:0] req_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    mem_rd,
  output logic                    mem_wr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  output logic [1:0]              grant_id
);

  localparam logic [1:0] NO_GRANT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [2:0]            pending, pending_n;
  logic [2:0]            slot_wr, slot_wr_n;
  logic [ADDR_WIDTH-1:0] slot_addr    [3];
  logic [ADDR_WIDTH-1:0] slot_addr_n  [3];
  logic [DATA_WIDTH-1:0] slot_wdata   [3];
  logic [DATA_WIDTH-1:0] slot_wdata_n [3];
  logic [DATA_WIDTH-1:0] rdata_q      [3];
  logic [DATA_WIDTH-1:0] rdata_n      [3];
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0] mem_wdata_n;
  logic                  mem_rd_n;
  logic                  mem_wr_n;
  logic [1:0]            grant_n;
  logic [1:0]            last, last_n;
  logic [1:0]            pick;
  logic                  pick_valid;

`ifdef SDRAM_ARB_HOSTPRIO_EN
  // Set when the most recent grant among requesters 1/2 went to requester 2.
  logic                  aux_two, aux_two_n;
`else
  logic [1:0]            first, second;
`endif

  // Modulo-3 successor of a requester index.
  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Busy is exactly the registered pending flag of each slot.
  assign req_busy = pending;

  // Flatten per-requester read data onto the packed output bus.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rdata
    assign req_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_q[gi];
  end

  // Arbitration: choose the requester to serve at the next IDLE decision.
  always_comb begin
    pick       = 2'd0;
    pick_valid = |pending;
`ifdef SDRAM_ARB_HOSTPRIO_EN
    if (pending[0])                    pick = 2'd0;
    else if (pending[1] && pending[2]) pick = aux_two ? 2'd1 : 2'd2;
    else if (pending[1])               pick = 2'd1;
    else                               pick = 2'd2;
`else
    first  = rr_next(last);
    second = rr_next(first);
    if (pending[first])       pick = first;
    else if (pending[second]) pick = second;
    else                      pick = last;
`endif
  end

  // Next-state logic: slot capture, command issue and completion.
  always_comb begin
    state_n     = state;
    pending_n   = pending;
    slot_wr_n   = slot_wr;
    for (int i = 0; i < 3; i++) begin
      slot_addr_n[i]  = slot_addr[i];
      slot_wdata_n[i] = slot_wdata[i];
      rdata_n[i]      = rdata_q[i];
    end
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_rd_n    = 1'b0;
    mem_wr_n    = 1'b0;
    grant_n     = grant_id;
    last_n      = last;
`ifdef SDRAM_ARB_HOSTPRIO_EN
    aux_two_n   = aux_two;
`endif

    // A free slot latches its request; a write strobe overrides a read.
    for (int i = 0; i < 3; i++) begin
      if (!pending[i] && (req_rd[i] || req_wr[i])) begin
        pending_n[i]    = 1'b1;
        slot_wr_n[i]    = req_wr[i];
        slot_addr_n[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        slot_wdata_n[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    case (state)
      IDLE: begin
        // mem_ack here belongs to nothing and is ignored.
        if (pick_valid) begin
          mem_addr_n  = slot_addr[pick];
          mem_wdata_n = slot_wdata[pick];
          mem_rd_n    = !slot_wr[pick];
          mem_wr_n    = slot_wr[pick];
          grant_n     = pick;
          last_n      = pick;
`ifdef SDRAM_ARB_HOSTPRIO_EN
          if (pick != 2'd0) aux_two_n = (pick == 2'd2);
`endif
          state_n     = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (state == ISSUE) state_n = WAIT;
        if (mem_ack) begin
          if (!slot_wr[grant_id]) rdata_n[grant_id] = mem_rdata;
          pending_n[grant_id] = 1'b0;
          grant_n             = NO_GRANT;
          state_n             = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = NO_GRANT;
      end
    endcase
  end

  // State and output registers with immediate clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      slot_wr   <= '0;
      for (int i = 0; i < 3; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
        rdata_q[i]    <= '0;
      end
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      grant_id  <= NO_GRANT;
      last      <= 2'd2;
`ifdef SDRAM_ARB_HOSTPRIO_EN
      aux_two   <= 1'b1;
`endif
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      slot_wr   <= slot_wr_n;
      for (int i = 0; i < 3; i++) begin
        slot_addr[i]  <= slot_addr_n[i];
        slot_wdata[i] <= slot_wdata_n[i];
        rdata_q[i]    <= rdata_n[i];
      end
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_rd    <= mem_rd_n;
      mem_wr    <= mem_wr_n;
      grant_id  <= grant_n;
      last      <= last_n;
`ifdef SDRAM_ARB_HOSTPRIO_EN
      aux_two   <= aux_two_n;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter. Inputs change on the
// falling edge; outputs are checked on the falling edge (or shortly after an
// asynchronous reset) against hand-computed values.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  localparam int AW = 23;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req_rd;
  logic [2:0]      req_wr;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      req_busy;
  logic [3*DW-1:0] req_rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rd;
  logic            mem_wr;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;
  logic [1:0]      grant_id;

  int compared   = 0;
  int mismatched = 0;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_busy  (req_busy),
    .req_rdata (req_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .grant_id  (grant_id)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wdata(input int i, input logic [DW-1:0] d);
    req_wdata[i*DW +: DW] = d;
  endtask

  // One-cycle strobe; returns at the falling edge after the capture edge.
  task automatic strobe(input logic [2:0] rd, input logic [2:0] wr);
    req_rd = rd;
    req_wr = wr;
    @(negedge clk);
    req_rd = '0;
    req_wr = '0;
  endtask

  // Called at the falling edge right after the issue edge. Checks the command,
  // acks it from WAIT and checks completion.
  task automatic serve(input string tag, input logic [1:0] g, input logic is_wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] ack_data);
    check({tag, " grant"}, grant_id, g);
    check({tag, " mem_rd"}, mem_rd, !is_wr);
    check({tag, " mem_wr"}, mem_wr, is_wr);
    check({tag, " mem_addr"}, mem_addr, a);
    if (is_wr) check({tag, " mem_wdata"}, mem_wdata, wd);
    @(negedge clk);
    check({tag, " cmd one pulse"}, {mem_rd, mem_wr}, 2'b00);
    check({tag, " busy held"}, req_busy[g], 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = ack_data;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check({tag, " grant idle"}, grant_id, 2'b11);
    check({tag, " busy drop"}, req_busy[g], 1'b0);
    if (!is_wr) check({tag, " rdata"}, req_rdata[g*DW +: DW], ack_data);
  endtask

  // Directed sequence.
  initial begin
    reset     = 1'b1;
    req_rd    = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("rst busy", req_busy, 3'b000);
    check("rst grant", grant_id, 2'b11);
    check("rst cmd", {mem_rd, mem_wr}, 2'b00);
    check("rst addr", mem_addr, '0);
    check("rst rdata", req_rdata, '0);

    // Single read from requester 1.
    set_addr(1, 23'h012345);
    strobe(3'b010, 3'b000);
    check("rd1 busy at capture", req_busy, 3'b010);
    check("rd1 no cmd yet", mem_rd, 1'b0);
    check("rd1 grant before issue", grant_id, 2'b11);
    @(negedge clk);
    serve("rd1", 2'd1, 1'b0, 23'h012345, 8'h00, 8'hA5);
    check("rd1 rdata bus", req_rdata, 24'h00A500);

    // Write then read from requester 0.
    set_addr(0, 23'h000100);
    set_wdata(0, 8'h3C);
    strobe(3'b000, 3'b001);
    check("wr0 busy", req_busy, 3'b001);
    @(negedge clk);
    serve("wr0", 2'd0, 1'b1, 23'h000100, 8'h3C, 8'h77);
    check("wr0 rdata untouched", req_rdata, 24'h00A500);
    strobe(3'b001, 3'b000);
    @(negedge clk);
    serve("rd0", 2'd0, 1'b0, 23'h000100, 8'h00, 8'h3C);
    check("rd0 rdata bus", req_rdata, 24'h00A53C);

    // Read and write strobed together on requester 2: write wins.
    set_addr(2, 23'h000200);
    set_wdata(2, 8'h5A);
    strobe(3'b100, 3'b100);
    check("rdwr2 busy", req_busy, 3'b100);
    @(negedge clk);
    serve("rdwr2", 2'd2, 1'b1, 23'h000200, 8'h5A, 8'h99);
    check("rdwr2 rdata untouched", req_rdata, 24'h00A53C);

    // Strobes while busy, including on the completion edge, are dropped.
    set_addr(1, 23'h000400);
    strobe(3'b010, 3'b000);
    @(negedge clk);
    check("dup issue rd", mem_rd, 1'b1);
    check("dup issue addr", mem_addr, 23'h000400);
    set_addr(1, 23'h7FFFFF);
    req_rd = 3'b010;
    @(negedge clk);
    check("dup no pulse", {mem_rd, mem_wr}, 2'b00);
    mem_ack   = 1'b1;
    mem_rdata = 8'h42;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    req_rd    = '0;
    check("dup busy clear", req_busy, 3'b000);
    check("dup grant idle", grant_id, 2'b11);
    check("dup rdata", req_rdata[DW +: DW], 8'h42);
    repeat (2) @(negedge clk);
    check("dup no extra cmd", {mem_rd, mem_wr}, 2'b00);
    check("dup still idle busy", req_busy, 3'b000);
    check("dup addr held", mem_addr, 23'h000400);

    // Reset while waiting for ack; a late ack must change nothing.
    set_addr(0, 23'h0ABCDE);
    strobe(3'b001, 3'b000);
    @(negedge clk);
    check("rstw issue", mem_rd, 1'b1);
    @(negedge clk);
    check("rstw waiting busy", req_busy, 3'b001);
    #2 reset = 1'b1;
    #1;
    check("rstw async busy", req_busy, 3'b000);
    check("rstw async cmd", {mem_rd, mem_wr}, 2'b00);
    check("rstw async grant", grant_id, 2'b11);
    check("rstw async addr", mem_addr, '0);
    check("rstw async rdata", req_rdata, '0);
    @(negedge clk);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("late ack rdata", req_rdata, '0);
    check("late ack busy", req_busy, 3'b000);
    check("late ack grant", grant_id, 2'b11);
    @(negedge clk);
    check("late ack no cmd", {mem_rd, mem_wr}, 2'b00);

    // Contention after reset: grant order 0,1,2.
    set_addr(0, 23'h000010);
    set_addr(1, 23'h000020);
    set_addr(2, 23'h000030);
    strobe(3'b111, 3'b000);
    check("cont busy all", req_busy, 3'b111);
    @(negedge clk);
    serve("cont0", 2'd0, 1'b0, 23'h000010, 8'h00, 8'hD0);
    check("cont busy after 0", req_busy, 3'b110);
    @(negedge clk);
    serve("cont1", 2'd1, 1'b0, 23'h000020, 8'h00, 8'hD1);
    check("cont busy after 1", req_busy, 3'b100);
    @(negedge clk);
    serve("cont2", 2'd2, 1'b0, 23'h000030, 8'h00, 8'hD2);
    check("cont busy after 2", req_busy, 3'b000);
    check("cont rdata bus", req_rdata, 24'hD2D1D0);

    // Requesters 0 and 1 re-strobing continuously: grants alternate 0,1,0,1.
    set_addr(0, 23'h000111);
    set_addr(1, 23'h000222);
    req_rd = 3'b011;
    @(negedge clk);
    check("alt busy", req_busy, 3'b011);
    @(negedge clk);
    serve("alt0", 2'd0, 1'b0, 23'h000111, 8'h00, 8'h10);
    @(negedge clk);
    serve("alt1", 2'd1, 1'b0, 23'h000222, 8'h00, 8'h11);
    @(negedge clk);
    serve("alt2", 2'd0, 1'b0, 23'h000111, 8'h00, 8'h12);
    req_rd = '0;
    @(negedge clk);
    serve("alt3", 2'd1, 1'b0, 23'h000222, 8'h00, 8'h13);
    check("alt busy end", req_busy, 3'b000);
    @(negedge clk);
    check("alt idle cmd", {mem_rd, mem_wr}, 2'b00);
    check("alt idle grant", grant_id, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
